// File: rtl/spi_slave_param.sv
// SPI slave with synchronized inputs, parameterised frame and payload widths.
// Replies with a loadable word (or ACK_WORD); supports back-to-back frames.
module spi_slave_param #(
  parameter int                    FRAME_BITS = 8,
  parameter int                    DATA_W     = 4,
  parameter logic [FRAME_BITS-1:0] ACK_WORD   = FRAME_BITS'(8'hA5),
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk_in,
  input  logic                  mosi_in,
  input  logic                  ss_n_in,
  input  logic [FRAME_BITS-1:0] tx_data_in,
  input  logic                  tx_load_in,
  output logic [DATA_W-1:0]     rx_data_out,
  output logic                  rx_valid_out,
  output logic                  frame_err_out,
  output logic                  busy_out,
  output logic                  miso_out
);

  localparam int CW = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DESEL,
    ACTIVE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_mosi_s1, r_mosi_s2;
  logic r_ss_s1, r_ss_s2, r_ss_d;

  logic [CW-1:0]         r_cnt;
  logic [FRAME_BITS-2:0] r_rx_sr;
  logic [FRAME_BITS-1:0] r_tx_sr;
  logic [FRAME_BITS-1:0] r_pend;
  logic [DATA_W-1:0]     r_rx_data;
  logic                  r_rx_valid;
  logic                  r_frame_err;

  logic w_rise, w_fall, w_lead, w_trail;
  logic w_samp_edge, w_shift_edge;
  logic w_ss_fall, w_ss_rise;
  logic w_start, w_samp, w_shift, w_err;
  logic w_done, w_reload;
  logic [FRAME_BITS-1:0] w_pend_word;

  assign w_rise  = r_sclk_s2 & ~r_sclk_d;
  assign w_fall  = ~r_sclk_s2 & r_sclk_d;
  assign w_lead  = CPOL ? w_fall : w_rise;
  assign w_trail = CPOL ? w_rise : w_fall;

  assign w_samp_edge  = (CPHA ? w_trail : w_lead) & ~r_ss_s2;
  assign w_shift_edge = (CPHA ? w_lead : w_trail) & ~r_ss_s2;

  assign w_ss_fall = r_ss_d & ~r_ss_s2;
  assign w_ss_rise = ~r_ss_d & r_ss_s2;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_samp      = 1'b0;
    w_shift     = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = ACTIVE;
          w_start     = 1'b1;
        end
      end
      WAIT_DESEL: begin
        if (r_ss_s2) w_state_nxt = IDLE;
      end
      ACTIVE: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          w_err       = (r_cnt != '0);
        end else begin
          w_samp  = w_samp_edge;
          // bit 0 of a frame is already on miso: no shift at count 0
          w_shift = w_shift_edge & (r_cnt != '0);
        end
      end
      default: w_state_nxt = WAIT_DESEL;
    endcase
  end

  assign w_done      = w_samp & (r_cnt == CW'(FRAME_BITS-1));
  assign w_reload    = w_start | w_done;
  assign w_pend_word = tx_load_in ? tx_data_in : r_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_mosi_s1   <= 1'b0;
      r_mosi_s2   <= 1'b0;
      r_ss_s1     <= 1'b0;
      r_ss_s2     <= 1'b0;
      r_ss_d      <= 1'b0;
      r_state     <= WAIT_DESEL;
      r_cnt       <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_pend      <= ACK_WORD;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sclk_s1   <= sclk_in;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_d    <= r_sclk_s2;
      r_mosi_s1   <= mosi_in;
      r_mosi_s2   <= r_mosi_s1;
      r_ss_s1     <= ss_n_in;
      r_ss_s2     <= r_ss_s1;
      r_ss_d      <= r_ss_s2;
      r_state     <= w_state_nxt;
      r_rx_valid  <= 1'b0;
      r_frame_err <= w_err;
      if (w_reload) begin
        r_tx_sr <= w_pend_word;
        r_pend  <= ACK_WORD;
      end else begin
        if (tx_load_in) r_pend <= tx_data_in;
        if (w_shift) r_tx_sr <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
      end
      if (w_start) r_cnt <= '0;
      if (w_samp) begin
        r_rx_sr <= {r_rx_sr[FRAME_BITS-3:0], r_mosi_s2};
        if (w_done) begin
          r_cnt      <= '0;
          r_rx_data  <= DATA_W'({r_rx_sr, r_mosi_s2}
                        >> (FRAME_BITS - DATA_W));
          r_rx_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign busy_out      = (r_state == ACTIVE);
  assign miso_out      = busy_out & r_tx_sr[FRAME_BITS-1];
  assign rx_data_out   = r_rx_data;
  assign rx_valid_out  = r_rx_valid;
  assign frame_err_out = r_frame_err;

endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench: mode-0 default slave plus a 16-bit mode-3 slave.
// Expected payloads are queued by stimulus and popped by monitors.
module tb_spi_slave_param;

  localparam int HALF = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        sclk0 = 1'b0, mosi0 = 1'b0, ss0 = 1'b1;
  logic [7:0]  tx_data0 = '0;
  logic        tx_load0 = 1'b0;
  logic [3:0]  rx0;
  logic        val0, err0, busy0, miso0;

  logic        sclk1 = 1'b1, mosi1 = 1'b0, ss1 = 1'b1;
  logic [15:0] tx_data1 = '0;
  logic        tx_load1 = 1'b0;
  logic [11:0] rx1;
  logic        val1, err1, busy1, miso1;

  spi_slave_param u0 (
    .clk(clk), .reset(reset),
    .sclk_in(sclk0), .mosi_in(mosi0), .ss_n_in(ss0),
    .tx_data_in(tx_data0), .tx_load_in(tx_load0),
    .rx_data_out(rx0), .rx_valid_out(val0),
    .frame_err_out(err0), .busy_out(busy0),
    .miso_out(miso0)
  );

  spi_slave_param #(
    .FRAME_BITS(16), .DATA_W(12),
    .ACK_WORD(16'h5AA5), .CPOL(1'b1), .CPHA(1'b1)
  ) u1 (
    .clk(clk), .reset(reset),
    .sclk_in(sclk1), .mosi_in(mosi1), .ss_n_in(ss1),
    .tx_data_in(tx_data1), .tx_load_in(tx_load1),
    .rx_data_out(rx1), .rx_valid_out(val1),
    .frame_err_out(err1), .busy_out(busy1),
    .miso_out(miso1)
  );

  int n_vec = 0;
  int n_bad = 0;
  int qe0   = 0;
  logic [3:0]  q0[$];
  logic [11:0] q1[$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (val0) begin
      if (q0.size() == 0) chk("rx0_unexpected", 1, 0);
      else chk("rx0", {28'd0, rx0}, {28'd0, q0.pop_front()});
    end
    if (val1) begin
      if (q1.size() == 0) chk("rx1_unexpected", 1, 0);
      else chk("rx1", {20'd0, rx1}, {20'd0, q1.pop_front()});
    end
    if (err0) begin
      if (qe0 == 0) chk("err0_unexpected", 1, 0);
      else begin
        n_vec++;
        qe0--;
      end
    end
    if (err1) chk("err1_unexpected", 1, 0);
  end

  task automatic f0(input logic [7:0] d,
                    input logic [7:0] exp_miso,
                    input int nbits);
    logic [7:0] r;
    r = '0;
    @(negedge clk);
    ss0 = 1'b0;
    #(2*HALF);
    chk("busy0", {31'd0, busy0}, 1);
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi0 = d[i];
      #HALF;
      sclk0 = 1'b1;
      r[i] = miso0;
      #HALF;
      sclk0 = 1'b0;
    end
    #(2*HALF);
    if (nbits == 8) chk("miso0", {24'd0, r}, {24'd0, exp_miso});
    ss0 = 1'b1;
    #(4*HALF);
  endtask

  task automatic f1(input logic [15:0] da, input logic [15:0] db,
                    input logic [15:0] ea, input logic [15:0] eb);
    logic [15:0] r;
    logic [15:0] w;
    @(negedge clk);
    ss1 = 1'b0;
    #(2*HALF);
    chk("busy1", {31'd0, busy1}, 1);
    for (int f = 0; f < 2; f++) begin
      w = (f == 0) ? da : db;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
        sclk1 = 1'b0;
        mosi1 = w[i];
        #HALF;
        sclk1 = 1'b1;
        r[i] = miso1;
        #HALF;
      end
      chk("miso1", {16'd0, r}, {16'd0, (f == 0) ? ea : eb});
    end
    #(2*HALF);
    ss1 = 1'b1;
    #(4*HALF);
  endtask

  task automatic summary;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
  endtask

  initial begin
    #1000000;
    chk("watchdog", 1, 0);
    summary();
    $finish;
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_rx0", {28'd0, rx0}, 0);
    chk("rst_val0", {31'd0, val0}, 0);
    chk("rst_err0", {31'd0, err0}, 0);
    chk("rst_busy0", {31'd0, busy0}, 0);
    chk("rst_miso0", {31'd0, miso0}, 0);
    chk("rst_rx1", {20'd0, rx1}, 0);
    chk("rst_busy1", {31'd0, busy1}, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    q0.push_back(4'h5);
    f0(8'h50, 8'hA5, 8);
    q0.push_back(4'hA);
    f0(8'hA0, 8'hA5, 8);
    q0.push_back(4'h0);
    f0(8'h00, 8'hA5, 8);

    @(negedge clk);
    tx_data0 = 8'h3C;
    tx_load0 = 1'b1;
    @(negedge clk);
    tx_load0 = 1'b0;
    q0.push_back(4'h1);
    f0(8'h12, 8'h3C, 8);
    q0.push_back(4'hF);
    f0(8'hF0, 8'hA5, 8);

    qe0++;
    f0(8'h6B, 8'h00, 5);
    chk("err_seen", qe0, 0);
    chk("rx0_hold", {28'd0, rx0}, 32'hF);
    q0.push_back(4'h9);
    f0(8'h90, 8'hA5, 8);

    @(negedge clk);
    tx_data1 = 16'hBEEF;
    tx_load1 = 1'b1;
    @(negedge clk);
    tx_load1 = 1'b0;
    q1.push_back(12'hABC);
    q1.push_back(12'h123);
    f1(16'hABC0, 16'h1230, 16'hBEEF, 16'h5AA5);

    @(negedge clk);
    ss0 = 1'b0;
    #(2*HALF);
    for (int i = 0; i < 4; i++) begin
      mosi0 = 1'b1;
      #HALF;
      sclk0 = 1'b1;
      #HALF;
      sclk0 = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy0", {31'd0, busy0}, 0);
    reset = 1'b0;
    #(2*HALF);
    chk("wait_busy0", {31'd0, busy0}, 0);
    for (int i = 0; i < 4; i++) begin
      mosi0 = 1'b1;
      #HALF;
      sclk0 = 1'b1;
      chk("wait_miso0", {31'd0, miso0}, 0);
      #HALF;
      sclk0 = 1'b0;
    end
    #(2*HALF);
    chk("wait_busy0b", {31'd0, busy0}, 0);
    ss0 = 1'b1;
    #(4*HALF);
    chk("rst_rx0_clr", {28'd0, rx0}, 0);
    q0.push_back(4'h7);
    f0(8'h70, 8'hA5, 8);

    repeat (20) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("qe0_drained", qe0, 0);
    summary();
    $finish;
  end

endmodule
